// File: rtl/counter_arb_pkg.sv
// Shared types and helpers for the counter request arbiter.
// Holds the FSM state type, the default counter base address and the priority encoder.
package counter_arb_pkg;

    localparam int MAX_CHAN      = 32;
    localparam int DEF_BASE_ADDR = 'o24;

    typedef enum logic {
        IDLE,
        SERVE
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } prio_t;

    // Lowest set bit wins; scanning downward lets the last hit be the lowest index.
    function automatic prio_t prio_first(input logic [MAX_CHAN-1:0] vec);
        prio_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_CHAN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_req_latch.sv
// One counter channel: rising-edge detect on the plus/minus pulse levels,
// request latches with opposing-request cancel, and a sticky lost-request flag.
module counter_req_latch (
    input  logic clk_i,
    input  logic rst_i,
    input  logic gojam_i,
    input  logic inc_p_i,
    input  logic inc_m_i,
    input  logic clr_i,
    input  logic ovr_clr_i,
    output logic p_lat_o,
    output logic m_lat_o,
    output logic ovr_o
);

    logic prev_p_q, prev_m_q;
    logic p_q, p_d;
    logic m_q, m_d;
    logic ovr_q, ovr_d;
    logic edge_p, edge_m, cancel, drop;

    always_comb begin
        edge_p = inc_p_i & ~prev_p_q;
        edge_m = inc_m_i & ~prev_m_q;
        cancel = p_q & m_q & ~clr_i;
        drop   = clr_i | cancel;
        // A new edge wins over a same-cycle clear so no pulse is dropped.
        p_d    = (p_q & ~drop) | edge_p;
        m_d    = (m_q & ~drop) | edge_m;
        ovr_d  = (ovr_q & ~ovr_clr_i)
               | (edge_p & p_q & ~drop)
               | (edge_m & m_q & ~drop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_p_q <= 1'b0;
            prev_m_q <= 1'b0;
            p_q      <= 1'b0;
            m_q      <= 1'b0;
            ovr_q    <= 1'b0;
        end else if (gojam_i) begin
            prev_p_q <= 1'b0;
            prev_m_q <= 1'b0;
            p_q      <= 1'b0;
            m_q      <= 1'b0;
        end else begin
            prev_p_q <= inc_p_i;
            prev_m_q <= inc_m_i;
            p_q      <= p_d;
            m_q      <= m_d;
            ovr_q    <= ovr_d;
        end
    end

    assign p_lat_o = p_q;
    assign m_lat_o = m_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/counter_request_arbiter.sv
// Fixed-priority arbiter for counter increment requests: latches per-channel
// plus/minus pulses and serves one channel per sequencer slot with CAD and PINC/MINC.
module counter_request_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NCHAN      = 16,
    parameter int ADDR_W     = 6,
    parameter int BASE_ADDR  = DEF_BASE_ADDR,
    parameter int SVC_CYCLES = 2
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              gojam,
    input  logic [NCHAN-1:0]  inc_p,
    input  logic [NCHAN-1:0]  inc_m,
    input  logic              svc_slot,
    input  logic              ovr_clr,
    output logic              rq,
    output logic              cvalid,
    output logic [ADDR_W-1:0] cad,
    output logic              pinc,
    output logic              minc,
    output logic [NCHAN-1:0]  overrun
);

    localparam int CNT_W = (SVC_CYCLES > 1) ? $clog2(SVC_CYCLES) : 1;

    if (NCHAN < 1 || NCHAN > MAX_CHAN) begin : g_bad_nchan
        $error("counter_request_arbiter: NCHAN must be in 1..32");
    end
    if (SVC_CYCLES < 1) begin : g_bad_svc
        $error("counter_request_arbiter: SVC_CYCLES must be >= 1");
    end
    if (BASE_ADDR + NCHAN - 1 > (1 << ADDR_W) - 1) begin : g_bad_addr
        $error("counter_request_arbiter: channel addresses exceed ADDR_W");
    end

    logic [NCHAN-1:0] p_lat, m_lat, pend, gnt;
    prio_t            pick;
    logic             grant;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cvalid_q, cvalid_d;
    logic [ADDR_W-1:0] cad_q, cad_d;
    logic              pinc_q, pinc_d;
    logic              minc_q, minc_d;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        assign gnt[i] = grant & (pick.idx == 5'(i));

        counter_req_latch u_latch (
            .clk_i     (CLOCK),
            .rst_i     (rst),
            .gojam_i   (gojam),
            .inc_p_i   (inc_p[i]),
            .inc_m_i   (inc_m[i]),
            .clr_i     (gnt[i]),
            .ovr_clr_i (ovr_clr),
            .p_lat_o   (p_lat[i]),
            .m_lat_o   (m_lat[i]),
            .ovr_o     (overrun[i])
        );
    end

    // A channel with both polarities latched is cancelling and is not a request.
    assign pend  = p_lat ^ m_lat;
    assign rq    = |pend;
    assign pick  = prio_first(MAX_CHAN'(pend));
    assign grant = (state_q == IDLE) & svc_slot & pick.found;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cvalid_d = cvalid_q;
        cad_d    = cad_q;
        pinc_d   = pinc_q;
        minc_d   = minc_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = SERVE;
                    cnt_d    = CNT_W'(SVC_CYCLES - 1);
                    cvalid_d = 1'b1;
                    cad_d    = ADDR_W'(BASE_ADDR) + ADDR_W'(pick.idx);
                    pinc_d   = |(gnt & p_lat);
                    minc_d   = |(gnt & m_lat);
                end
            end
            SERVE: begin
                // Slots offered while serving are dropped, not queued.
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    cvalid_d = 1'b0;
                    cad_d    = '0;
                    pinc_d   = 1'b0;
                    minc_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (rst || gojam) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cvalid_q <= 1'b0;
            cad_q    <= '0;
            pinc_q   <= 1'b0;
            minc_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cvalid_q <= cvalid_d;
            cad_q    <= cad_d;
            pinc_q   <= pinc_d;
            minc_q   <= minc_d;
        end
    end

    assign cvalid = cvalid_q;
    assign cad    = cad_q;
    assign pinc   = pinc_q;
    assign minc   = minc_q;

endmodule

// File: tb/tb_counter_request_arbiter.sv
// Bench for counter_request_arbiter: directed test-plan scenarios plus a random
// phase, all checked every cycle against a request/service-time model.
module tb_counter_request_arbiter;

    localparam int N    = 16;
    localparam int AW   = 6;
    localparam int BASE = 'o24;
    localparam int SVC  = 2;

    logic          CLOCK = 1'b0;
    logic          rst = 1'b1, gojam = 1'b0, svc_slot = 1'b0, ovr_clr = 1'b0;
    logic [N-1:0]  inc_p = '0, inc_m = '0;
    logic          rq, cvalid, pinc, minc;
    logic [AW-1:0] cad;
    logic [N-1:0]  overrun;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    counter_request_arbiter #(
        .NCHAN(N), .ADDR_W(AW), .BASE_ADDR(BASE), .SVC_CYCLES(SVC)
    ) dut (
        .CLOCK(CLOCK), .rst(rst), .gojam(gojam), .inc_p(inc_p), .inc_m(inc_m),
        .svc_slot(svc_slot), .ovr_clr(ovr_clr), .rq(rq), .cvalid(cvalid),
        .cad(cad), .pinc(pinc), .minc(minc), .overrun(overrun)
    );

    always #5 CLOCK = ~CLOCK;

    // Model: request bits, last input levels, sticky loss flags, and the
    // number of clocks the current grant stays visible.
    logic [N-1:0]  mp = '0, mm = '0, mprev_p = '0, mprev_m = '0, movr = '0;
    int            rem = 0;
    logic [AW-1:0] ecad = '0;
    logic          epinc = 1'b0, eminc = 1'b0;

    always @(posedge CLOCK) begin
        logic [N-1:0]  p, m, o;
        int            r, g;
        logic [AW-1:0] c;
        logic          ep_o, em_o, ep, em, gone;
        p = mp; m = mm; o = movr; r = rem; c = ecad; ep_o = epinc; em_o = eminc;
        if (rst || gojam) begin
            p = '0; m = '0; r = 0; c = '0; ep_o = 0; em_o = 0;
            if (rst) o = '0;
            mprev_p <= '0;
            mprev_m <= '0;
        end else begin
            g = -1;
            if (r == 0 && svc_slot)
                for (int i = N - 1; i >= 0; i--) if (p[i] != m[i]) g = i;
            if (g >= 0) begin
                r = SVC; c = AW'(BASE + g); ep_o = p[g]; em_o = m[g];
            end else if (r > 0) begin
                r = r - 1;
                if (r == 0) begin c = '0; ep_o = 0; em_o = 0; end
            end
            for (int i = 0; i < N; i++) begin
                ep   = inc_p[i] && !mprev_p[i];
                em   = inc_m[i] && !mprev_m[i];
                gone = (i == g) || (p[i] && m[i]);
                if (ovr_clr) o[i] = 1'b0;
                if ((ep && p[i] && !gone) || (em && m[i] && !gone)) o[i] = 1'b1;
                p[i] = (p[i] && !gone) || ep;
                m[i] = (m[i] && !gone) || em;
            end
            mprev_p <= inc_p;
            mprev_m <= inc_m;
        end
        mp <= p; mm <= m; movr <= o; rem <= r; ecad <= c; epinc <= ep_o; eminc <= em_o;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (check_en) begin
            chk("model_outputs", 64'({rq, cvalid, cad, pinc, minc, overrun}),
                64'({|(mp ^ mm), rem > 0, ecad, epinc, eminc, movr}));
            chk("pinc_minc_excl", 64'(pinc & minc), 64'd0);
        end
    end

    task automatic step();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        check_en = 1'b1;
        chk("reset_outputs", 64'({rq, cvalid, cad, pinc, minc, overrun}), 64'd0);
        repeat (20) step();
        chk("idle_outputs", 64'({rq, cvalid, cad, overrun}), 64'd0);

        // Single plus on channel 3
        inc_p[3] = 1'b1; step();
        inc_p = '0; svc_slot = 1'b1; step();
        svc_slot = 1'b0;
        chk("single_cad", 64'(cad), 64'(6'o27));
        chk("single_cmd", 64'({cvalid, pinc, minc}), 64'b110);
        chk("model_pin_cad", 64'(ecad), 64'(6'o27));
        step();
        chk("single_hold", 64'(cvalid), 64'd1);
        step();
        chk("single_done", 64'({rq, cvalid, cad}), 64'd0);

        // Priority: channel 1 plus beats channel 5 minus
        inc_m[5] = 1'b1; inc_p[1] = 1'b1; step();
        inc_m = '0; inc_p = '0; svc_slot = 1'b1; step();
        svc_slot = 1'b0;
        chk("prio1_cad", 64'(cad), 64'(6'o25));
        chk("prio1_cmd", 64'({pinc, minc}), 64'b10);
        step(); step(); step();
        svc_slot = 1'b1; step();
        svc_slot = 1'b0;
        chk("prio2_cad", 64'(cad), 64'(6'o31));
        chk("prio2_cmd", 64'({pinc, minc}), 64'b01);
        step(); step();

        // Cancel on channel 2
        inc_p[2] = 1'b1; step();
        inc_p = '0; inc_m[2] = 1'b1; step();
        inc_m = '0; step();
        chk("cancel_rq", 64'(rq), 64'd0);
        svc_slot = 1'b1; step();
        svc_slot = 1'b0;
        chk("cancel_nogrant", 64'(cvalid), 64'd0);

        // Overrun on channel 7, single grant
        inc_p[7] = 1'b1; step();
        inc_p = '0; step();
        inc_p[7] = 1'b1; step();
        inc_p = '0;
        chk("ovr_set", 64'(overrun), 64'h0080);
        chk("model_pin_ovr", 64'(movr), 64'h0080);
        svc_slot = 1'b1; step();
        svc_slot = 1'b0;
        chk("ovr_grant", 64'({cvalid, cad, pinc}), 64'({1'b1, 6'o33, 1'b1}));
        step(); step();
        svc_slot = 1'b1; step();
        svc_slot = 1'b0;
        chk("ovr_single", 64'(cvalid), 64'd0);

        // Re-latch in the grant cycle
        inc_p[7] = 1'b1; step();
        inc_p = '0; step();
        svc_slot = 1'b1; inc_p[7] = 1'b1; step();
        svc_slot = 1'b0; inc_p = '0;
        chk("relatch_grant", 64'({cvalid, rq}), 64'b11);
        step(); step();
        svc_slot = 1'b1; step();
        svc_slot = 1'b0;
        chk("relatch_second", 64'({cvalid, cad}), 64'({1'b1, 6'o33}));
        step(); step();
        ovr_clr = 1'b1; step();
        ovr_clr = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);

        // gojam in the second serve cycle
        inc_p[4] = 1'b1; step();
        inc_p = '0; step();
        inc_p[4] = 1'b1; step();
        inc_p = '0; inc_m[9] = 1'b1; step();
        inc_m = '0;
        svc_slot = 1'b1; step();
        svc_slot = 1'b0;
        chk("gojam_grant", 64'({cvalid, cad}), 64'({1'b1, 6'o30}));
        step();
        gojam = 1'b1; step();
        gojam = 1'b0;
        chk("gojam_abort", 64'({cvalid, rq, pinc}), 64'd0);
        chk("gojam_keep_ovr", 64'(overrun), 64'h0010);

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            inc_p    = N'($urandom) & N'($urandom) & N'($urandom);
            inc_m    = N'($urandom) & N'($urandom) & N'($urandom);
            svc_slot = ($urandom_range(0, 2) == 0);
            ovr_clr  = ($urandom_range(0, 19) == 0);
            gojam    = ($urandom_range(0, 199) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; gojam = 1'b0; svc_slot = 1'b0; ovr_clr = 1'b0;
        inc_p = '0; inc_m = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
